video_scan_gen: RTL and testbench

VIDEO_SCAN_GEN -- requirements
Module: video_scan_gen

---
 rtl/video_scan_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_video_scan_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_scan_gen
// Function : DVI raster timing generator with scaled VRAM fetch; sync/de are
//            delayed two stages to meet the synchronous VRAM read data.
//            Optional colour-bar source: VIDEO_SCAN_GEN_TESTPAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module video_scan_gen #(
  parameter int   H_BPORCH   = 220,
  parameter int   H_ACTIVE   = 1280,
  parameter int   H_FPORCH   = 110,
  parameter int   H_SYNC     = 40,
  parameter logic H_POLAR    = 1'b1,
  parameter int   V_BPORCH   = 20,
  parameter int   V_ACTIVE   = 720,
  parameter int   V_FPORCH   = 5,
  parameter int   V_SYNC     = 5,
  parameter logic V_POLAR    = 1'b1,
  parameter int   SCALE_LOG2 = 3,
  parameter int   CNT_W      = 12,
  parameter int   ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
`ifdef VIDEO_SCAN_GEN_TESTPAT_EN
  input  logic              test_mode,
`endif
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [23:0]       vram_rdata,
  output logic              rgb_hs,
  output logic              rgb_vs,
  output logic              rgb_de,
  output logic [7:0]        rgb_r,
  output logic [7:0]        rgb_g,
  output logic [7:0]        rgb_b,
  output logic              line_start,
  output logic              frame_start,
  output logic [15:0]       frame_cnt
);

  localparam int c_h_total = H_BPORCH + H_ACTIVE + H_FPORCH + H_SYNC;
  localparam int c_v_total = V_BPORCH + V_ACTIVE + V_FPORCH + V_SYNC;

  localparam logic [CNT_W-1:0] c_h_last     = CNT_W'(c_h_total - 1);
  localparam logic [CNT_W-1:0] c_h_act_beg  = CNT_W'(H_BPORCH);
  localparam logic [CNT_W-1:0] c_h_act_end  = CNT_W'(H_BPORCH + H_ACTIVE);
  localparam logic [CNT_W-1:0] c_h_sync_beg = CNT_W'(H_BPORCH + H_ACTIVE + H_FPORCH);
  localparam logic [CNT_W-1:0] c_v_last     = CNT_W'(c_v_total - 1);
  localparam logic [CNT_W-1:0] c_v_act_beg  = CNT_W'(V_BPORCH);
  localparam logic [CNT_W-1:0] c_v_act_end  = CNT_W'(V_BPORCH + V_ACTIVE);
  localparam logic [CNT_W-1:0] c_v_sync_beg = CNT_W'(V_BPORCH + V_ACTIVE + V_FPORCH);
  localparam logic [ADDR_W-1:0] c_cols      = ADDR_W'(H_ACTIVE >> SCALE_LOG2);

  // Scan counters and frame counter
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic [15:0]      r_frame_cnt;
  logic             w_h_wrap;
  logic             w_v_wrap;

  assign w_h_wrap = (r_h == c_h_last);
  assign w_v_wrap = (r_v == c_v_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h         <= '0;
      r_v         <= '0;
      r_frame_cnt <= '0;
    end else if (!en) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_wrap) begin
      r_h <= '0;
      if (w_v_wrap) begin
        r_v         <= '0;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_v <= r_v + CNT_W'(1);
      end
    end else begin
      r_h <= r_h + CNT_W'(1);
    end
  end

  // Stage 0: decode of the current counter state
  logic              w_de0;
  logic              w_hs0;
  logic              w_vs0;
  logic              w_ls0;
  logic              w_fs0;
  logic [CNT_W-1:0]  w_x;
  logic [CNT_W-1:0]  w_y;
  logic [ADDR_W-1:0] w_addr;

  assign w_de0 = (r_h >= c_h_act_beg) && (r_h < c_h_act_end) &&
                 (r_v >= c_v_act_beg) && (r_v < c_v_act_end);
  assign w_hs0 = (r_h >= c_h_sync_beg) ? H_POLAR : ~H_POLAR;
  assign w_vs0 = (r_v >= c_v_sync_beg) ? V_POLAR : ~V_POLAR;
  // Pulses are gated by en so a held-at-zero scan does not repeat them
  assign w_ls0 = en && (r_h == '0);
  assign w_fs0 = w_ls0 && (r_v == '0);

  assign w_x    = r_h - c_h_act_beg;
  assign w_y    = r_v - c_v_act_beg;
  assign w_addr = ADDR_W'(w_x >> SCALE_LOG2) + ADDR_W'(w_y >> SCALE_LOG2) * c_cols;

  // Stage 1: address issue and first alignment register
  logic [ADDR_W-1:0] r_vram_addr;
  logic              r_de1;
  logic              r_hs1;
  logic              r_vs1;
  logic              r_ls1;
  logic              r_fs1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vram_addr <= '0;
      r_de1       <= 1'b0;
      r_hs1       <= ~H_POLAR;
      r_vs1       <= ~V_POLAR;
      r_ls1       <= 1'b0;
      r_fs1       <= 1'b0;
    end else begin
      if (w_de0) begin
        r_vram_addr <= w_addr;
      end
      r_de1 <= w_de0;
      r_hs1 <= w_hs0;
      r_vs1 <= w_vs0;
      r_ls1 <= w_ls0;
      r_fs1 <= w_fs0;
    end
  end

  // Stage 2: aligned with vram_rdata
  logic r_de2;
  logic r_hs2;
  logic r_vs2;
  logic r_ls2;
  logic r_fs2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_de2 <= 1'b0;
      r_hs2 <= ~H_POLAR;
      r_vs2 <= ~V_POLAR;
      r_ls2 <= 1'b0;
      r_fs2 <= 1'b0;
    end else begin
      r_de2 <= r_de1;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      r_ls2 <= r_ls1;
      r_fs2 <= r_fs1;
    end
  end

  logic [23:0] w_pix;

`ifdef VIDEO_SCAN_GEN_TESTPAT_EN
  localparam logic [CNT_W-1:0] c_bar_w = CNT_W'(H_ACTIVE / 8);

  logic [2:0]  w_bar_idx;
  logic [23:0] w_bar_rgb;
  logic [23:0] r_bar1;
  logic [23:0] r_bar2;
  logic        r_tm1;
  logic        r_tm2;

  always_comb begin
    w_bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (w_x >= CNT_W'(i) * c_bar_w) begin
        w_bar_idx = 3'(i);
      end
    end
  end

  always_comb begin
    w_bar_rgb = 24'h000000;
    case (w_bar_idx)
      3'd0:    w_bar_rgb = 24'hFFFFFF;
      3'd1:    w_bar_rgb = 24'hFFFF00;
      3'd2:    w_bar_rgb = 24'h00FFFF;
      3'd3:    w_bar_rgb = 24'h00FF00;
      3'd4:    w_bar_rgb = 24'hFF00FF;
      3'd5:    w_bar_rgb = 24'hFF0000;
      3'd6:    w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase
  end

  // Bar colour and its select follow the same two-stage path as de
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bar1 <= '0;
      r_bar2 <= '0;
      r_tm1  <= 1'b0;
      r_tm2  <= 1'b0;
    end else begin
      r_bar1 <= w_bar_rgb;
      r_bar2 <= r_bar1;
      r_tm1  <= test_mode;
      r_tm2  <= r_tm1;
    end
  end

  assign w_pix = r_tm2 ? r_bar2 : vram_rdata;
`else
  assign w_pix = vram_rdata;
`endif

  assign {rgb_r, rgb_g, rgb_b} = r_de2 ? w_pix : 24'h000000;
  assign rgb_de      = r_de2;
  assign rgb_hs      = r_hs2;
  assign rgb_vs      = r_vs2;
  assign line_start  = r_ls2;
  assign frame_start = r_fs2;
  assign vram_addr   = r_vram_addr;
  assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_video_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_scan_gen
// Function : Scoreboard bench for video_scan_gen on a 24x12 raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_scan_gen;

  localparam int HBP = 4, HA = 16, HFP = 2, HSW = 2;
  localparam int VBP = 2, VA = 8,  VFP = 1, VSW = 1;
  localparam int SL  = 1;
  localparam int HT  = HBP + HA + HFP + HSW;
  localparam int VT  = VBP + VA + VFP + VSW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic        tm  = 1'b0;
  logic [15:0] vram_addr;
  logic [23:0] vram_rdata;
  logic        rgb_hs, rgb_vs, rgb_de;
  logic [7:0]  rgb_r, rgb_g, rgb_b;
  logic        line_start, frame_start;
  logic [15:0] frame_cnt;

  video_scan_gen #(
    .H_BPORCH(HBP), .H_ACTIVE(HA), .H_FPORCH(HFP), .H_SYNC(HSW), .H_POLAR(1'b1),
    .V_BPORCH(VBP), .V_ACTIVE(VA), .V_FPORCH(VFP), .V_SYNC(VSW), .V_POLAR(1'b1),
    .SCALE_LOG2(SL), .CNT_W(12), .ADDR_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
`ifdef VIDEO_SCAN_GEN_TESTPAT_EN
    .test_mode(tm),
`endif
    .vram_addr(vram_addr),
    .vram_rdata(vram_rdata),
    .rgb_hs(rgb_hs),
    .rgb_vs(rgb_vs),
    .rgb_de(rgb_de),
    .rgb_r(rgb_r),
    .rgb_g(rgb_g),
    .rgb_b(rgb_b),
    .line_start(line_start),
    .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous VRAM whose contents equal the address
  always @(posedge clk) vram_rdata <= {8'h00, vram_addr};

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [23:0] rgb;
  } out_t;

  typedef struct {
    int   h;
    int   v;
    logic tm;
    out_t o;
  } exp_t;

  typedef struct {
    string name;
    logic  en;
    int    cycles;
    int    fcnt;
    int    de_n;
    int    hs_n;
    int    vs_n;
  } phase_t;

  exp_t        exp_q[$];
  phase_t      ph[4];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_h, m_v;
  logic [15:0] m_fcnt;
  out_t        obs;
  int          cnt_de, cnt_hs, cnt_vs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic out_t model_out(input int h, input int v, input logic e, input logic t);
    out_t o;
    int   a;
    o.de = (h >= HBP) && (h < HBP + HA) && (v >= VBP) && (v < VBP + VA);
    o.hs = (h >= HBP + HA + HFP);
    o.vs = (v >= VBP + VA + VFP);
    o.ls = e && (h == 0);
    o.fs = e && (h == 0) && (v == 0);
    a    = ((h - HBP) >> SL) + ((v - VBP) >> SL) * (HA >> SL);
    if (!o.de)  o.rgb = 24'h0;
    else if (t) o.rgb = bar_rgb((h - HBP) / (HA / 8));
    else        o.rgb = 24'(a);
    return o;
  endfunction

  // Reset state with active-high polarity: syncs low, everything else zero
  function automatic exp_t reset_exp();
    exp_t e;
    e.h  = -1;
    e.v  = -1;
    e.tm = 1'b0;
    e.o  = '0;
    return e;
  endfunction

  task automatic restart_model();
    m_h    = 0;
    m_v    = 0;
    m_fcnt = 16'd0;
    exp_q.delete();
    exp_q.push_back(reset_exp());
    exp_q.push_back(reset_exp());
  endtask

  // Called just after a rising edge: push the expectation for this cycle,
  // compare the outputs of two cycles ago at the falling edge, then advance.
  task automatic tick();
    exp_t e, f;
    e.h  = m_h;
    e.v  = m_v;
    e.tm = tm;
    e.o  = model_out(m_h, m_v, en, tm);
    exp_q.push_back(e);
    @(negedge clk);
    obs = {rgb_de, rgb_hs, rgb_vs, line_start, frame_start, rgb_r, rgb_g, rgb_b};
    f   = exp_q.pop_front();
    check("outputs{de,hs,vs,ls,fs,rgb}", 32'(obs), 32'(f.o));
    check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    if (!f.tm && f.h == HBP     && f.v == VBP)     check("first_px_rgb", 32'(obs.rgb), 32'h000000);
    if (!f.tm && f.h == HBP + 2 && f.v == VBP)     check("px_x2_rgb",    32'(obs.rgb), 32'h000001);
    if (!f.tm && f.h == HBP     && f.v == VBP + 2) check("line2_px0_rgb", 32'(obs.rgb), 32'h000008);
    if (f.tm && f.v == VBP && (f.h == HBP || f.h == HBP + 1))
      check("bar_white", 32'(obs.rgb), 32'hFFFFFF);
    if (f.tm && f.v == VBP && (f.h == HBP + 10 || f.h == HBP + 11))
      check("bar_red", 32'(obs.rgb), 32'hFF0000);
    if (f.tm && f.v == VBP && (f.h == HBP + 14 || f.h == HBP + 15))
      check("bar_black", 32'(obs.rgb), 32'h000000);
    if (obs.de) cnt_de++;
    if (obs.hs) cnt_hs++;
    if (obs.vs) cnt_vs++;
    @(posedge clk);
    #1;
    if (!en) begin
      m_h = 0;
      m_v = 0;
    end else if (m_h == HT - 1) begin
      m_h = 0;
      if (m_v == VT - 1) begin
        m_v    = 0;
        m_fcnt = m_fcnt + 16'd1;
      end else begin
        m_v = m_v + 1;
      end
    end else begin
      m_h = m_h + 1;
    end
  endtask

  task automatic check_reset_now(input string tag);
    out_t now;
    now = {rgb_de, rgb_hs, rgb_vs, line_start, frame_start, rgb_r, rgb_g, rgb_b};
    check({tag, "_outputs"}, 32'(now), 32'(reset_exp().o));
    check({tag, "_vram_addr"}, 32'(vram_addr), 32'h0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   guard;
    logic [15:0] fc_saved;

    // Observed states per phase lag the scan by two cycles; see counts below
    ph[0] = '{"two_frames",  1'b1, 576, 2, 256, 48, 48};
    ph[1] = '{"third_frame", 1'b1, 288, 3, 128, 24, 24};
    ph[2] = '{"en_low_hold", 1'b0,  20, 3,   0,  0,  0};
    ph[3] = '{"resume",      1'b1, 288, 4, 128, 22, 22};

    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_now("reset_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
    restart_model();
    tick();
    tick();

    for (int p = 0; p < 4; p++) begin
      en     = ph[p].en;
      cnt_de = 0;
      cnt_hs = 0;
      cnt_vs = 0;
      repeat (ph[p].cycles) tick();
      check({ph[p].name, "_frame_cnt"}, 32'(frame_cnt), 32'(ph[p].fcnt));
      check({ph[p].name, "_de_cycles"}, cnt_de, ph[p].de_n);
      check({ph[p].name, "_hs_cycles"}, cnt_hs, ph[p].hs_n);
      check({ph[p].name, "_vs_cycles"}, cnt_vs, ph[p].vs_n);
    end

    // en drop for 5 cycles at h=10, v=5
    en    = 1'b1;
    guard = 0;
    while (!(m_h == 10 && m_v == 5) && guard < 400) begin
      tick();
      guard++;
    end
    check("reach_drop_point", 32'(m_h == 10 && m_v == 5), 32'h1);
    fc_saved = frame_cnt;
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    tick();
    tick();
    check("drop_fs_early", 32'(obs.fs), 32'h0);
    tick();
    check("drop_fs_at_2", 32'(obs.fs), 32'h1);
    check("drop_ls_at_2", 32'(obs.ls), 32'h1);
    check("drop_frame_cnt", 32'(frame_cnt), 32'(fc_saved));

    // Asynchronous reset mid-line while de is active
    guard = 0;
    while (!(m_h == HBP + 6 && m_v == VBP + 2) && guard < 400) begin
      tick();
      guard++;
    end
    check("pre_rst_de", 32'(rgb_de), 32'h1);
    check("pre_rst_rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'h00000A);
    #2;
    rst = 1'b1;
    #1;
    check_reset_now("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    restart_model();
    tick();
    tick();
    cnt_de = 0;
    repeat (VT * HT) tick();
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'h1);

`ifdef VIDEO_SCAN_GEN_TESTPAT_EN
    tm = 1'b1;
    repeat (VT * HT) tick();
    tm = 1'b0;
    repeat (4) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
